// File: rtl/ao22_arb_pkg.sv
// Shared types and parameter-legality helpers for the AO22 share arbiter.
// Owner states, dead-counter width and elaboration checks.
package ao22_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } arb_state_e;

    localparam int DEAD_W = 3;

endpackage

// Elaboration-time guard: a failing condition stops the build.
`define AO22_ARB_REQUIRE(lbl, cond, msg) \
    if (!(cond)) begin : lbl \
        $fatal(1, msg); \
    end

// File: rtl/ao22_share_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
// The arbiter side drives grants, selects, beat count and preempt.
interface ao22_share_arbiter_if #(
    parameter int CNT_W = 8
);

    logic             REQ0;
    logic             REQ1;
    logic             LAST0;
    logic             LAST1;
    logic             GNT0;
    logic             GNT1;
    logic             SEL0;
    logic             SEL1;
    logic [CNT_W-1:0] BEATS;
    logic             PREEMPT;

    modport master (
        input  REQ0,
        input  REQ1,
        input  LAST0,
        input  LAST1,
        output GNT0,
        output GNT1,
        output SEL0,
        output SEL1,
        output BEATS,
        output PREEMPT
    );

    modport slave (
        output REQ0,
        output REQ1,
        output LAST0,
        output LAST1,
        input  GNT0,
        input  GNT1,
        input  SEL0,
        input  SEL1,
        input  BEATS,
        input  PREEMPT
    );

endinterface

// File: rtl/ao22_rr_pick.sv
// Two-way round-robin pick; last_i=1 means requester 1 owned last,
// so requester 0 wins a tie.
module ao22_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic pick0_o,
    output logic pick1_o
);

    assign pick0_o = req0_i & (~req1_i | last_i);
    assign pick1_o = req1_i & (~req0_i | ~last_i);

endmodule

// File: rtl/ao22_share_arbiter.sv
// Sequences SEL0/SEL1 of the shared AO22 bus column with dead cycles,
// bounded bursts and round-robin fairness.
module ao22_share_arbiter
    import ao22_arb_pkg::*;
#(
    parameter int MAX_BURST   = 8,
    parameter int DEAD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    ao22_share_arbiter_if.master bus
);

    `AO22_ARB_REQUIRE(g_chk_dead_lo, DEAD_CYCLES >= 1,
        "DEAD_CYCLES must be at least 1")
    `AO22_ARB_REQUIRE(g_chk_dead_hi, DEAD_CYCLES <= (2**DEAD_W) - 1,
        "DEAD_CYCLES exceeds dead counter")
    `AO22_ARB_REQUIRE(g_chk_burst, (MAX_BURST >= 0) && (MAX_BURST <= 255),
        "MAX_BURST must be 0..255")
    `AO22_ARB_REQUIRE(g_chk_cnt, MAX_BURST <= (2**CNT_W) - 1,
        "CNT_W too narrow for MAX_BURST")

    localparam logic [CNT_W-1:0] BEAT_MAX = '1;
    localparam logic [CNT_W-1:0] BURST_END =
        CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [DEAD_W-1:0] DEAD_LD = DEAD_W'(DEAD_CYCLES);
    localparam logic [DEAD_W-1:0] DEAD_ONE = DEAD_W'(1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              pre_q, pre_d;
    logic              gnt0_q, gnt1_q;

    logic       pick0, pick1;
    arb_state_e win;
    logic       side1, cur_req, cur_last, oth_req, forced;

    ao22_rr_pick u_pick (
        .req0_i  (bus.REQ0),
        .req1_i  (bus.REQ1),
        .last_i  (last_q),
        .pick0_o (pick0),
        .pick1_o (pick1)
    );

    always_comb begin
        win = IDLE;
        if (pick0) begin
            win = OWN0;
        end else if (pick1) begin
            win = OWN1;
        end
    end

    assign side1    = (state_q == OWN1);
    assign cur_req  = side1 ? bus.REQ1  : bus.REQ0;
    assign cur_last = side1 ? bus.LAST1 : bus.LAST0;
    assign oth_req  = side1 ? bus.REQ0  : bus.REQ1;
    assign forced   = (MAX_BURST != 0) && (beats_q == BURST_END) && oth_req;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beats_d = beats_q;
        dead_d  = dead_q;
        pre_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = win;
            end
            OWN0, OWN1: begin
                if (!cur_req || cur_last || forced) begin
                    state_d = TURN;
                    last_d  = side1;
                    beats_d = '0;
                    dead_d  = DEAD_LD;
                    // A normal LAST or drop takes priority over preemption
                    pre_d   = cur_req && !cur_last;
                end else if (beats_q != BEAT_MAX) begin
                    beats_d = beats_q + 1'b1;
                end
            end
            TURN: begin
                if (dead_q == DEAD_ONE) begin
                    state_d = win;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grants come straight from flops so the AO22 selects never glitch
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beats_q <= '0;
            dead_q  <= '0;
            pre_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            dead_q  <= dead_d;
            pre_q   <= pre_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
        end
    end

    assign bus.GNT0    = gnt0_q;
    assign bus.GNT1    = gnt1_q;
    assign bus.SEL0    = gnt0_q;
    assign bus.SEL1    = gnt1_q;
    assign bus.BEATS   = beats_q;
    assign bus.PREEMPT = pre_q;

endmodule

// File: tb/tb_ao22_share_arbiter.sv
// Bench for ao22_share_arbiter: three parameterisations driven by one
// stimulus stream, each checked against an ownership-level model.
module tb_ao22_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;
    bit   r0, r1, l0, l1;
    int   checks = 0;
    int   errors = 0;

    ao22_share_arbiter_if #(.CNT_W(8)) ifa ();
    ao22_share_arbiter_if #(.CNT_W(8)) ifb ();
    ao22_share_arbiter_if #(.CNT_W(8)) ifc ();

    assign ifa.REQ0 = r0;
    assign ifa.REQ1 = r1;
    assign ifa.LAST0 = l0;
    assign ifa.LAST1 = l1;
    assign ifb.REQ0 = r0;
    assign ifb.REQ1 = r1;
    assign ifb.LAST0 = l0;
    assign ifb.LAST1 = l1;
    assign ifc.REQ0 = r0;
    assign ifc.REQ1 = r1;
    assign ifc.LAST0 = l0;
    assign ifc.LAST1 = l1;

    ao22_share_arbiter #(.MAX_BURST(8), .DEAD_CYCLES(1), .CNT_W(8)) dut_a (
        .CLK (clk), .RSTB (rstb), .bus (ifa)
    );
    ao22_share_arbiter #(.MAX_BURST(0), .DEAD_CYCLES(1), .CNT_W(8)) dut_b (
        .CLK (clk), .RSTB (rstb), .bus (ifb)
    );
    ao22_share_arbiter #(.MAX_BURST(8), .DEAD_CYCLES(3), .CNT_W(8)) dut_c (
        .CLK (clk), .RSTB (rstb), .bus (ifc)
    );

    a_excl_a: assert property (@(posedge clk) disable iff (!rstb)
        !(ifa.SEL0 && ifa.SEL1)) else $error("FAIL sel_overlap_a");
    a_excl_b: assert property (@(posedge clk) disable iff (!rstb)
        !(ifb.SEL0 && ifb.SEL1)) else $error("FAIL sel_overlap_b");
    a_excl_c: assert property (@(posedge clk) disable iff (!rstb)
        !(ifc.SEL0 && ifc.SEL1)) else $error("FAIL sel_overlap_c");

    // Model: who owns the bus, how long, and how much dead time is left
    typedef struct {
        int owner;
        int held;
        int gap;
        int last;
        bit pre;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t step(mdl_t m, int maxb, int dead,
                                 bit rst, bit q0, bit q1, bit f0, bit f1);
        mdl_t n = m;
        bit   r, l, o;
        n.pre = 1'b0;
        if (rst) begin
            n.owner = -1;
            n.held  = 0;
            n.gap   = 0;
            n.last  = 1;
            return n;
        end
        if (m.owner >= 0) begin
            r = (m.owner == 1) ? q1 : q0;
            l = (m.owner == 1) ? f1 : f0;
            o = (m.owner == 1) ? q0 : q1;
            if (!r || l || (maxb != 0 && m.held == maxb - 1 && o)) begin
                n.pre   = r && !l;
                n.last  = m.owner;
                n.owner = -1;
                n.held  = 0;
                n.gap   = dead;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            if (m.gap > 0) n.gap = m.gap - 1;
            if (n.gap == 0) begin
                if (q0 && (!q1 || m.last == 1)) n.owner = 0;
                else if (q1) n.owner = 1;
                n.held = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp(string nm, mdl_t m, logic g0, logic g1, logic s0,
                       logic s1, logic pr, logic [7:0] bt);
        int eb;
        eb = (m.owner >= 0) ? ((m.held > 255) ? 255 : m.held) : 0;
        chk({nm, ".gnt0"}, 32'(g0), 32'(m.owner == 0));
        chk({nm, ".gnt1"}, 32'(g1), 32'(m.owner == 1));
        chk({nm, ".sel0"}, 32'(s0), 32'(m.owner == 0));
        chk({nm, ".sel1"}, 32'(s1), 32'(m.owner == 1));
        chk({nm, ".preempt"}, 32'(pr), 32'(m.pre));
        chk({nm, ".beats"}, 32'(bt), eb);
    endtask

    task automatic tick();
        @(posedge clk);
        ma = step(ma, 8, 1, !rstb, r0, r1, l0, l1);
        mb = step(mb, 0, 1, !rstb, r0, r1, l0, l1);
        mc = step(mc, 8, 3, !rstb, r0, r1, l0, l1);
        #1;
        cmp("a", ma, ifa.GNT0, ifa.GNT1, ifa.SEL0, ifa.SEL1,
            ifa.PREEMPT, ifa.BEATS);
        cmp("b", mb, ifb.GNT0, ifb.GNT1, ifb.SEL0, ifb.SEL1,
            ifb.PREEMPT, ifb.BEATS);
        cmp("c", mc, ifc.GNT0, ifc.GNT1, ifc.SEL0, ifc.SEL1,
            ifc.PREEMPT, ifc.BEATS);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
    endtask

    initial begin
        int n, nh, np, gap, prev, hand, grants, bad, g0seen;
        bit seen, pg;
        rstb = 1'b0;
        r0 = 0; r1 = 0; l0 = 0; l1 = 0;
        tick();
        tick();
        chk("rst.gnt0", 32'(ifa.GNT0), 0);
        chk("rst.gnt1", 32'(ifa.GNT1), 0);
        chk("rst.beats", 32'(ifa.BEATS), 0);
        chk("rst.preempt", 32'(ifa.PREEMPT), 0);

        // tie from reset release, LAST0 handoff
        r0 = 1; r1 = 1; rstb = 1'b1;
        tick();
        chk("tie.gnt0_c1", 32'(ifa.GNT0), 1);
        tick();
        tick();
        l0 = 1;
        tick();
        l0 = 0;
        chk("tie.gnt0_c4", 32'(ifa.GNT0), 0);
        chk("tie.gnt1_c4", 32'(ifa.GNT1), 0);
        tick();
        chk("tie.gnt1_c5", 32'(ifa.GNT1), 1);

        // forced release after MAX_BURST beats
        n = 0;
        while (ifa.GNT1 && n < 20) begin n++; tick(); end
        chk("pre.len1", n, 8);
        chk("pre.pulse1", 32'(ifa.PREEMPT), 1);
        tick();
        chk("pre.next0", 32'(ifa.GNT0), 1);
        chk("pre.pulse_off", 32'(ifa.PREEMPT), 0);
        n = 0;
        while (ifa.GNT0 && n < 20) begin n++; tick(); end
        chk("pre.len0", n, 8);
        chk("pre.pulse0", 32'(ifa.PREEMPT), 1);

        // unlimited burst on dut_b
        do_reset();
        tick();
        nh = 0; np = 0;
        for (int i = 0; i < 300; i++) begin
            if (ifb.GNT0) nh++;
            if (ifb.PREEMPT) np++;
            tick();
        end
        chk("unl.held", nh, 300);
        chk("unl.preempts", np, 0);
        chk("unl.beats_sat", 32'(ifb.BEATS), 255);

        // dead-cycle sweep on dut_c with LAST on every first beat
        do_reset();
        gap = 0; prev = -1; hand = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.GNT0 || ifc.GNT1) begin
                if (seen && gap > 0) begin
                    chk("dead.gap", gap, 3);
                    chk("dead.alt", 32'(ifc.GNT1 ? 1 : 0),
                        32'(prev == 0 ? 1 : 0));
                    hand++;
                end
                seen = 1;
                prev = ifc.GNT1 ? 1 : 0;
                gap = 0;
            end else begin
                gap++;
            end
            l0 = ifc.GNT0;
            l1 = ifc.GNT1;
            tick();
        end
        l0 = 0; l1 = 0;
        chk("dead.handoffs", 32'(hand >= 5), 1);

        // single requester repeats 2-beat grants
        r0 = 0; r1 = 1;
        do_reset();
        grants = 0; bad = 0; g0seen = 0; gap = 0; pg = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifa.GNT0) g0seen++;
            if (ifa.GNT1 && !pg) begin
                grants++;
                if (grants > 1 && gap != 1) bad++;
            end
            gap = ifa.GNT1 ? 0 : gap + 1;
            pg = ifa.GNT1;
            l1 = ifa.GNT1 && (ifa.BEATS == 8'd1);
            tick();
        end
        l1 = 0;
        chk("rep.gnt0_never", g0seen, 0);
        chk("rep.bad_gaps", bad, 0);
        chk("rep.grants", 32'(grants >= 10), 1);

        // reset in the middle of a grant
        r0 = 1; r1 = 0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("mid.pre_gnt0", 32'(ifa.GNT0), 1);
        rstb = 1'b0;
        tick();
        chk("mid.gnt0", 32'(ifa.GNT0), 0);
        chk("mid.beats", 32'(ifa.BEATS), 0);
        rstb = 1'b1;
        tick();
        chk("mid.regrant", 32'(ifa.GNT0), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r0 = ($urandom % 4) != 0;
            r1 = ($urandom % 4) != 0;
            l0 = ($urandom % 5) == 0;
            l1 = ($urandom % 5) == 0;
            rstb = ($urandom % 200) != 0;
            tick();
        end
        rstb = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
